aes_round_sequencer: RTL



---
 rtl/aes_round_sequencer.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/aes_round_sequencer.sv
// Control FSM for an iterative AES-128 encryption datapath: one INIT cycle, then a
// SUB/MIX cycle pair per round. Outputs are registered copies of the next-state decode.
module aes_round_sequencer #(
    parameter int unsigned NR = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic       state_load,
    output logic       key_load,
    output logic       state_en,
    output logic       key_en,
    output logic       sub_phase,
    output logic       skip_mix,
    output logic [7:0] rcon,
    output logic [3:0] round,
    output logic       busy,
    output logic       done
);

    localparam int unsigned ROUND_W = 4;
    localparam int unsigned FSM_W   = 3;
    localparam int unsigned RCON_W  = 8;

    localparam logic [FSM_W-1:0] S_IDLE = 3'd0;
    localparam logic [FSM_W-1:0] S_INIT = 3'd1;
    localparam logic [FSM_W-1:0] S_SUB  = 3'd2;
    localparam logic [FSM_W-1:0] S_MIX  = 3'd3;
    localparam logic [FSM_W-1:0] S_DONE = 3'd4;

    localparam logic [ROUND_W-1:0] LAST_ROUND = ROUND_W'(NR);

    logic [FSM_W-1:0]   fsm_d, fsm_q;
    logic [ROUND_W-1:0] round_d, round_q;
    logic               state_load_d, state_load_q;
    logic               key_load_d, key_load_q;
    logic               state_en_d, state_en_q;
    logic               key_en_d, key_en_q;
    logic               sub_phase_d, sub_phase_q;
    logic               skip_mix_d, skip_mix_q;
    logic [RCON_W-1:0]  rcon_d, rcon_q;
    logic               busy_d, busy_q;
    logic               done_d, done_q;

    function automatic logic [RCON_W-1:0] rcon_of(input logic [ROUND_W-1:0] r);
        case (r)
            4'd1:    rcon_of = 8'h01;
            4'd2:    rcon_of = 8'h02;
            4'd3:    rcon_of = 8'h04;
            4'd4:    rcon_of = 8'h08;
            4'd5:    rcon_of = 8'h10;
            4'd6:    rcon_of = 8'h20;
            4'd7:    rcon_of = 8'h40;
            4'd8:    rcon_of = 8'h80;
            4'd9:    rcon_of = 8'h1b;
            4'd10:   rcon_of = 8'h36;
            default: rcon_of = 8'h00;
        endcase
    endfunction

    // Next state and round counter; start is only honoured in IDLE and DONE
    always_comb begin
        fsm_d   = fsm_q;
        round_d = round_q;
        case (fsm_q)
            S_IDLE: begin
                round_d = '0;
                if (start) fsm_d = S_INIT;
            end
            S_INIT: begin
                fsm_d   = S_SUB;
                round_d = 4'd1;
            end
            S_SUB: fsm_d = S_MIX;
            S_MIX: begin
                if (round_q >= LAST_ROUND) begin
                    fsm_d = S_DONE;
                end else begin
                    fsm_d   = S_SUB;
                    round_d = round_q + 4'd1;
                end
            end
            S_DONE: begin
                if (start) begin
                    fsm_d   = S_INIT;
                    round_d = '0;
                end
            end
            default: begin
                fsm_d   = S_IDLE;
                round_d = '0;
            end
        endcase
    end

    // Moore decode of the upcoming state so every output comes straight from a flop
    always_comb begin
        state_load_d = 1'b0;
        key_load_d   = 1'b0;
        state_en_d   = 1'b0;
        key_en_d     = 1'b0;
        sub_phase_d  = 1'b0;
        skip_mix_d   = 1'b0;
        rcon_d       = '0;
        busy_d       = 1'b0;
        done_d       = 1'b0;
        case (fsm_d)
            S_INIT: begin
                state_load_d = 1'b1;
                key_load_d   = 1'b1;
                busy_d       = 1'b1;
            end
            S_SUB: begin
                sub_phase_d = 1'b1;
                busy_d      = 1'b1;
                rcon_d      = rcon_of(round_d);
                skip_mix_d  = (round_d == LAST_ROUND);
            end
            S_MIX: begin
                state_en_d = 1'b1;
                key_en_d   = 1'b1;
                busy_d     = 1'b1;
                rcon_d     = rcon_of(round_d);
                skip_mix_d = (round_d == LAST_ROUND);
            end
            S_DONE:  done_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fsm_q        <= S_IDLE;
            round_q      <= '0;
            state_load_q <= 1'b0;
            key_load_q   <= 1'b0;
            state_en_q   <= 1'b0;
            key_en_q     <= 1'b0;
            sub_phase_q  <= 1'b0;
            skip_mix_q   <= 1'b0;
            rcon_q       <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            fsm_q        <= fsm_d;
            round_q      <= round_d;
            state_load_q <= state_load_d;
            key_load_q   <= key_load_d;
            state_en_q   <= state_en_d;
            key_en_q     <= key_en_d;
            sub_phase_q  <= sub_phase_d;
            skip_mix_q   <= skip_mix_d;
            rcon_q       <= rcon_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign state_load = state_load_q;
    assign key_load   = key_load_q;
    assign state_en   = state_en_q;
    assign key_en     = key_en_q;
    assign sub_phase  = sub_phase_q;
    assign skip_mix   = skip_mix_q;
    assign rcon       = rcon_q;
    assign round      = round_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule
